// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I ALU and its two-requester sharing controller:
// opcode constants, controller FSM encoding and the illegal-opcode threshold.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_LUI   = 4'd10;
  localparam logic [3:0] ALU_AUIPC = 4'd11;

  // Opcodes at or above this value are reserved and flagged as errors.
  localparam logic [3:0] ALU_ILLEGAL_MIN = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic is_illegal(input logic [3:0] op);
    return op >= ALU_ILLEGAL_MIN;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// Shared combinational RV32I ALU. Shift amounts use the full src2 value;
// reserved opcodes produce zero.
module ALU
  import alu_pkg::*;
(
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] src2,
  input  logic [1:0]      jump,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = '0;
    case (alu_control)
      // JAL/JALR reuse the adder to produce the link address.
      ALU_ADD:   result = (jump == 2'b01 || jump == 2'b10) ? pc + 32'd4 : rs1 + src2;
      ALU_SUB:   result = rs1 - src2;
      ALU_AND:   result = rs1 & src2;
      ALU_OR:    result = rs1 | src2;
      ALU_XOR:   result = rs1 ^ src2;
      ALU_SLL:   result = rs1 << src2;
      ALU_SRL:   result = rs1 >> src2;
      ALU_SRA:   result = $signed(rs1) >>> src2;
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(src2)};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, rs1 < src2};
      ALU_LUI:   result = src2;
      ALU_AUIPC: result = pc + src2;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter and IDLE/EXEC/RESP sequencer sharing one ALU between
// the execute stage (requester 0) and the address/aux unit (requester 1).
module alu_share_ctrl
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_rs1,
  input  logic [XLEN-1:0] req0_src2,
  input  logic [3:0]      req0_alu_control,
  input  logic [1:0]      req0_jump,
  input  logic [XLEN-1:0] req0_pc,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_rs1,
  input  logic [XLEN-1:0] req1_src2,
  input  logic [3:0]      req1_alu_control,
  input  logic [1:0]      req1_jump,
  input  logic [XLEN-1:0] req1_pc,

  output logic            resp0_valid,
  input  logic            resp0_ready,
  output logic [XLEN-1:0] resp0_result,
  output logic            resp0_err,

  output logic            resp1_valid,
  input  logic            resp1_ready,
  output logic [XLEN-1:0] resp1_result,
  output logic            resp1_err,

  output logic            busy
);

  state_e          state_reg;
  logic            prio_reg;
  logic            owner_reg;
  logic [3:0]      ctrl_reg;
  logic [1:0]      jump_reg;
  logic [XLEN-1:0] rs1_reg;
  logic [XLEN-1:0] src2_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] result_reg;
  logic            err_reg;

  logic            grant;
  logic            accept;
  logic            resp_accept;
  logic [XLEN-1:0] alu_result;

  // Only contention consults the priority pointer; a lone valid always wins.
  always_comb begin
    grant = (req0_valid && req1_valid) ? prio_reg : req1_valid;
  end

  assign req0_ready  = rst_n && (state_reg == IDLE) && req0_valid && !grant;
  assign req1_ready  = rst_n && (state_reg == IDLE) && req1_valid && grant;
  assign accept      = req0_ready || req1_ready;
  assign resp_accept = owner_reg ? resp1_ready : resp0_ready;

  assign resp0_valid  = (state_reg == RESP) && !owner_reg;
  assign resp1_valid  = (state_reg == RESP) && owner_reg;
  assign resp0_result = result_reg;
  assign resp1_result = result_reg;
  assign resp0_err    = err_reg;
  assign resp1_err    = err_reg;
  assign busy         = (state_reg != IDLE);

  ALU u_alu (
    .alu_control (ctrl_reg),
    .rs1         (rs1_reg),
    .src2        (src2_reg),
    .jump        (jump_reg),
    .pc          (pc_reg),
    .result      (alu_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      prio_reg   <= 1'b0;
      owner_reg  <= 1'b0;
      ctrl_reg   <= '0;
      jump_reg   <= '0;
      rs1_reg    <= '0;
      src2_reg   <= '0;
      pc_reg     <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            rs1_reg   <= grant ? req1_rs1 : req0_rs1;
            src2_reg  <= grant ? req1_src2 : req0_src2;
            ctrl_reg  <= grant ? req1_alu_control : req0_alu_control;
            jump_reg  <= grant ? req1_jump : req0_jump;
            pc_reg    <= grant ? req1_pc : req0_pc;
            owner_reg <= grant;
            prio_reg  <= ~grant;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          result_reg <= alu_result;
          err_reg    <= is_illegal(ctrl_reg);
          state_reg  <= RESP;
        end
        RESP: begin
          if (resp_accept) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: expected responses are queued at each
// request handshake and popped when the owning response appears.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_rs1, req0_src2, req0_pc, req1_rs1, req1_src2, req1_pc;
  logic [3:0]  req0_alu_control, req1_alu_control;
  logic [1:0]  req0_jump, req1_jump;
  logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [31:0] resp0_result, resp1_result;
  logic        resp0_err, resp1_err;
  logic        busy;

  always #5 clk = ~clk;

  alu_share_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rs1(req0_rs1),
    .req0_src2(req0_src2), .req0_alu_control(req0_alu_control),
    .req0_jump(req0_jump), .req0_pc(req0_pc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rs1(req1_rs1),
    .req1_src2(req1_src2), .req1_alu_control(req1_alu_control),
    .req1_jump(req1_jump), .req1_pc(req1_pc),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_result(resp0_result), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_result(resp1_result), .resp1_err(resp1_err),
    .busy(busy)
  );

  typedef struct {
    bit          owner;
    logic [31:0] res;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int n);
    return (n != 0) ? req1_ready : req0_ready;
  endfunction

  function automatic logic rvalid(input int n);
    return (n != 0) ? resp1_valid : resp0_valid;
  endfunction

  task automatic set_req(input int n, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] j, input logic [31:0] pc);
    if (n == 0) begin
      req0_alu_control = op; req0_rs1 = a; req0_src2 = b; req0_jump = j; req0_pc = pc;
      req0_valid = 1'b1;
    end else begin
      req1_alu_control = op; req1_rs1 = a; req1_src2 = b; req1_jump = j; req1_pc = pc;
      req1_valid = 1'b1;
    end
  endtask

  // Drop valid and scramble the fields; the accepted operands must be unaffected.
  task automatic clr_req(input int n);
    if (n == 0) begin
      req0_valid = 1'b0; req0_rs1 = 32'hDEAD_BEEF; req0_src2 = 32'h1234_5678;
      req0_alu_control = ALU_XOR; req0_jump = 2'b00; req0_pc = 32'hFFFF_0000;
    end else begin
      req1_valid = 1'b0; req1_rs1 = 32'hDEAD_BEEF; req1_src2 = 32'h1234_5678;
      req1_alu_control = ALU_XOR; req1_jump = 2'b00; req1_pc = 32'hFFFF_0000;
    end
  endtask

  task automatic push(input int n, input logic [31:0] res, input logic err);
    exp_t e;
    e.owner = (n != 0);
    e.res   = res;
    e.err   = err;
    sb.push_back(e);
  endtask

  // Entered at negedge+1; returns at negedge+1 in the cycle after acceptance.
  task automatic wait_resp(input int hold);
    exp_t e;
    int   o;
    int   cyc = 0;
    if (sb.size() == 0) begin
      total++; bad++;
      $error("FAIL sb_underflow observed=%0d expected=%0d", 0, 1);
      return;
    end
    e = sb.pop_front();
    o = e.owner ? 1 : 0;
    while (!rvalid(o) && cyc < 8) begin
      @(negedge clk); #1; cyc++;
    end
    check("resp_valid", {31'b0, rvalid(o)}, 32'd1);
    check("resp_other_valid", {31'b0, rvalid(1 - o)}, 32'd0);
    check("resp0_result", resp0_result, e.res);
    check("resp1_result", resp1_result, e.res);
    check("resp_err", {31'b0, (o != 0) ? resp1_err : resp0_err}, {31'b0, e.err});
    // The non-owner's ready must not release the response.
    if (o == 0) resp1_ready = 1'b1; else resp0_ready = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      check("hold_valid", {31'b0, rvalid(o)}, 32'd1);
      check("hold_result", resp0_result, e.res);
      check("hold_rdy", {30'b0, req1_ready, req0_ready}, 32'd0);
      check("hold_busy", {31'b0, busy}, 32'd1);
    end
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    if (o == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
    @(negedge clk);
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    #1;
    check("resp_drop", {31'b0, rvalid(o)}, 32'd0);
    check("idle_busy", {31'b0, busy}, 32'd0);
    $display("txn owner=%0d result=%h err=%b hold=%0d", o, e.res, e.err, hold);
  endtask

  task automatic run_op(input int n, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] j, input logic [31:0] pc,
                        input logic [31:0] exp_res, input logic exp_err, input int hold);
    @(negedge clk);
    set_req(n, op, a, b, j, pc);
    #1;
    check("op_ready", {31'b0, rdy(n)}, 32'd1);
    check("op_other_ready", {31'b0, rdy(1 - n)}, 32'd0);
    check("op_busy_idle", {31'b0, busy}, 32'd0);
    push(n, exp_res, exp_err);
    @(negedge clk);
    clr_req(n);
    #1;
    check("exec_busy", {31'b0, busy}, 32'd1);
    check("exec_no_resp", {30'b0, resp1_valid, resp0_valid}, 32'd0);
    @(negedge clk); #1;
    check("resp_at_t2", {31'b0, rvalid(n)}, 32'd1);
    wait_resp(hold);
  endtask

  task automatic contend(input int first, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1);
    int second = 1 - first;
    @(negedge clk);
    set_req(0, ALU_ADD, a0, b0, 2'b00, 32'h0);
    set_req(1, ALU_ADD, a1, b1, 2'b00, 32'h0);
    #1;
    check("cont_first_ready", {31'b0, rdy(first)}, 32'd1);
    check("cont_other_ready", {31'b0, rdy(second)}, 32'd0);
    push(first, (first != 0) ? a1 + b1 : a0 + b0, 1'b0);
    @(negedge clk);
    clr_req(first);
    #1;
    check("cont_exec_ready", {31'b0, rdy(second)}, 32'd0);
    @(negedge clk); #1;
    wait_resp(0);
    check("cont_second_ready", {31'b0, rdy(second)}, 32'd1);
    push(second, (second != 0) ? a1 + b1 : a0 + b0, 1'b0);
    @(negedge clk);
    clr_req(second);
    #1;
    @(negedge clk); #1;
    wait_resp(0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    clr_req(0); clr_req(1);
    req0_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
    check("rst_resp_valid", {30'b0, resp1_valid, resp0_valid}, 32'd0);
    check("rst_result0", resp0_result, 32'd0);
    check("rst_result1", resp1_result, 32'd0);
    check("rst_err", {30'b0, resp1_err, resp0_err}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Contention from reset, then alternation.
    contend(0, 32'd10, 32'd20, 32'd100, 32'd200);
    contend(0, 32'd1, 32'd2, 32'd3, 32'd4);

    run_op(0, ALU_ADD,   32'd5,         32'd7,          2'b00, 32'h0,   32'd12,        1'b0, 0);
    // prio now points at requester 1.
    contend(1, 32'd7, 32'd8, 32'd9, 32'd10);

    run_op(1, ALU_SRA,   32'h8000_0000, 32'd4,          2'b00, 32'h0,   32'hF800_0000, 1'b0, 5);
    run_op(0, ALU_ADD,   32'd55,        32'd66,         2'b01, 32'h100, 32'h104,       1'b0, 0);
    run_op(1, ALU_ADD,   32'd55,        32'd66,         2'b10, 32'h200, 32'h204,       1'b0, 1);
    run_op(0, ALU_AUIPC, 32'd9,         32'h2000,       2'b00, 32'h100, 32'h2100,      1'b0, 0);
    run_op(1, 4'b1110,   32'd3,         32'd4,          2'b00, 32'h0,   32'd0,         1'b1, 2);
    run_op(0, ALU_SUB,   32'd3,         32'd5,          2'b00, 32'h0,   32'hFFFF_FFFE, 1'b0, 0);
    run_op(1, ALU_SLT,   32'hFFFF_FFFF, 32'd1,          2'b00, 32'h0,   32'd1,         1'b0, 0);
    run_op(0, ALU_SLTU,  32'hFFFF_FFFF, 32'd1,          2'b00, 32'h0,   32'd0,         1'b0, 0);
    run_op(1, ALU_SLL,   32'd1,         32'd33,         2'b00, 32'h0,   32'd0,         1'b0, 0);
    run_op(0, ALU_SRL,   32'h8000_0000, 32'd31,         2'b00, 32'h0,   32'd1,         1'b0, 0);
    run_op(1, ALU_LUI,   32'd77,        32'h1234_5000,  2'b00, 32'h0,   32'h1234_5000, 1'b0, 0);
    run_op(0, ALU_XOR,   32'h0000_F0F0, 32'h0000_FF00,  2'b00, 32'h0,   32'h0000_0FF0, 1'b0, 0);
    run_op(1, 4'b1100,   32'd1,         32'd1,          2'b00, 32'h0,   32'd0,         1'b1, 0);

    // Reset during EXEC; prio is 1 after this handshake, reset must clear it.
    @(negedge clk);
    set_req(0, ALU_ADD, 32'd1, 32'd2, 2'b00, 32'h0);
    #1;
    check("mid_ready", {31'b0, req0_ready}, 32'd1);
    @(negedge clk);
    clr_req(0);
    #1;
    check("mid_exec_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
    check("mid_rst_valid", {30'b0, resp1_valid, resp0_valid}, 32'd0);
    check("mid_rst_result", resp0_result, 32'd0);
    check("mid_rst_err", {30'b0, resp1_err, resp0_err}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("post_rst_no_resp", {30'b0, resp1_valid, resp0_valid}, 32'd0);
      check("post_rst_busy", {31'b0, busy}, 32'd0);
    end
    contend(0, 32'd11, 32'd22, 32'd33, 32'd44);

    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Two-requester arbiter and sequencer for the single shared 32-bit RV32I ALU. It accepts operation requests from the execute stage (requester 0) and the address-generation/auxiliary unit (requester 1) over valid/ready handshakes. Arbitration is round-robin. Each accepted operation is sequenced through one registered-operand ALU pass, and the result is held in a response register until the owning requester accepts it.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- reqN_valid  input  1  requester N (N = 0, 1) presents an operation.
- reqN_ready  output  1  controller accepts requester N's operation this cycle.
- reqN_rs1  input  XLEN  operand A.
- reqN_src2  input  XLEN  operand B (register or immediate).
- reqN_alu_control  input  4  ALU opcode (ALU_ADD..ALU_AUIPC).
- reqN_jump  input  2  jump type; 01/10 make ALU_ADD return pc+4.
- reqN_pc  input  XLEN  instruction PC for AUIPC and link values.
- respN_valid  output  1  result available for requester N.
- respN_ready  input  1  requester N accepts the result.
- respN_result  output  XLEN  ALU result.
- respN_err  output  1  opcode was illegal (4'b1100–4'b1111).
- busy  output  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - Grant is combinational from the valids and the priority pointer `prio`.
  - If only one requester is valid, it is granted.
  - If both are valid, requester `prio` is granted.
  - `reqN_ready` = (state == IDLE) && grant == N. At most one ready is high.
- **Handshake** (`reqN_valid && reqN_ready`):
  - Latch rs1, src2, alu_control, jump and pc into the operand registers.
  - Latch owner = N.
  - Set `prio` to the requester not granted (1 − N).
  - Go to EXEC.
- **EXEC**
  - The ALU evaluates the latched operands.
  - Capture the result into the result register.
  - err = (alu_control ≥ 4'b1100). An illegal opcode produces result 0.
  - Go to RESP.
- **RESP**
  - `resp[owner]_valid` = 1; the other response valid is 0.
  - `respN_result` and `respN_err` are driven from the shared result register to both ports. They are meaningful only while the matching valid is high.
  - On `resp[owner]_ready`, go to IDLE.
  - The other requester's ready is ignored.
- **Request stability**: once asserted, a requester holds `valid` and its fields until ready. The controller does not re-sample after the handshake, so operand changes after acceptance have no effect.
- **ALU semantics**: identical to the shared ALU.
  - Shifts use the full src2 value, unmasked.
  - SLT/SLTU return 0 or 1.
  - LUI returns src2.
  - AUIPC returns pc + src2.
  - All arithmetic wraps modulo 2^32.
- **Reset mid-operation**: any state returns to IDLE immediately.
  - The in-flight operation is discarded and produces no response.
  - `prio` returns to 0.

## Timing
- Reset values:
  - resp0_valid, resp1_valid = 0.
  - respN_result = 0, respN_err = 0.
  - busy = 0; reqN_ready = 0 while rst_n is low.
  - Internal: `prio` = 0, owner = 0, operand registers = 0.
- Request handshake in cycle T; EXEC in T+1; respN_valid high from T+2.
- The response is held stable until the accepting cycle. Valid drops the cycle after the response handshake.
- A response accepted in cycle R allows the next request to be accepted in R+1, at the earliest. Minimum spacing between request handshakes is 3 cycles.
- No combinational path from respN_ready to reqN_ready.
- busy = 1 from T+1 through the response-accept cycle inclusive.

## Structure
- Shared package `alu_pkg` holds:
  - the ALU opcode constants ALU_ADD..ALU_AUIPC;
  - the FSM state encoding;
  - the illegal-opcode threshold.
- Instantiate the existing `ALU` module once as a sub-module, fed from the operand registers. Do not re-implement its logic.
- Remaining logic is the arbiter, FSM, operand/result registers and response muxing.

## Test plan
- **Single requester**: req0 sends ADD 5 + 7 at T.
  - req0_ready = 1 at T.
  - resp0_valid at T+2 with result 12 and err 0.
  - resp1_valid stays 0.
- **Contention from reset**: req0 and req1 both valid.
  - req0 is granted first.
  - req1 is granted after resp0 is accepted.
  - Next contention grants req0 again (alternation).
- **Backpressure**: req1 sends SRA 0x8000_0000 >>> 4; resp1_ready is held 0 for 5 cycles.
  - resp1_result is 0xF800_0000, stable throughout.
  - Both reqN_ready stay 0 until acceptance.
- **Jump/AUIPC**:
  - ADD with jump=01, pc=0x100 returns 0x104.
  - AUIPC with pc=0x100, src2=0x2000 returns 0x2100.
- **Illegal opcode**: alu_control = 4'b1110 returns result 0 with err 1.
- **Reset mid-operation**: assert rst_n = 0 during EXEC.
  - All outputs return to reset values asynchronously.
  - No response is produced after release.
  - The first post-reset contention grants req0.
